// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// default count width.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
//   master: drives load/start/abort/tick/autoReload, observes status
//   slave : the timer itself
//   io_load/io_loadValue : capture a new count + reload value (IDLE only)
//   io_start             : begin counting (IDLE only)
//   io_abort             : stop counting, no done pulse
//   io_tick              : decrement enable while running
//   io_autoReload        : at expiry, 1 = reload and continue, 0 = stop
//   io_value/io_busy/io_done/io_zero : count, running, expiry pulse, count==0
interface countdown_timer_if #(
  parameter int WIDTH = countdown_timer_pkg::DEFAULT_WIDTH
) ();

  logic             io_load;
  logic [WIDTH-1:0] io_loadValue;
  logic             io_start;
  logic             io_abort;
  logic             io_tick;
  logic             io_autoReload;
  logic [WIDTH-1:0] io_value;
  logic             io_busy;
  logic             io_done;
  logic             io_zero;

  modport master (
    output io_load, io_loadValue, io_start, io_abort, io_tick, io_autoReload,
    input  io_value, io_busy, io_done, io_zero
  );

  modport slave (
    input  io_load, io_loadValue, io_start, io_abort, io_tick, io_autoReload,
    output io_value, io_busy, io_done, io_zero
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable countdown timer with optional auto-reload.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   io    : countdown_timer_if slave (control inputs, status outputs)
// The tick source (prescaler) lives outside this block.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  countdown_timer_if.slave io
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] eff_count;
  logic             expire;

  // A load in the same cycle as start takes effect for the start decision.
  assign eff_count = io.io_load ? io.io_loadValue : count_q;

  // Expiry on the tick that would take the count from 1 to 0. Using <= 1
  // keeps a (never expected) zero count in RUN from wrapping to all-ones.
  assign expire = (state_q == RUN) && !io.io_abort && io.io_tick &&
                  (count_q <= WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (io.io_start && (eff_count != '0)) state_d = RUN;
      RUN: begin
        if (io.io_abort)                          state_d = IDLE;
        else if (expire && !io.io_autoReload)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next count / reload / done
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.io_load) begin
          count_d  = io.io_loadValue;
          reload_d = io.io_loadValue;
        end
        // Starting from zero expires at once without ever running.
        if (io.io_start && (eff_count == '0)) done_d = 1'b1;
      end
      RUN: begin
        if (expire) begin
          done_d  = 1'b1;
          count_d = io.io_autoReload ? reload_q : '0;
        end else if (!io.io_abort && io.io_tick) begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    io.io_value = count_q;
    io.io_busy  = (state_q == RUN);
    io.io_done  = done_q;
    io.io_zero  = (count_q == '0);
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 4: width of the count and load value.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 io_load  input  1  capture io_loadValue into the count and reload registers (IDLE only).
REQ-005 io_loadValue  input  WIDTH  value used by io_load.
REQ-006 io_start  input  1  begin counting down (IDLE only).
REQ-007 io_abort  input  1  stop counting, return to IDLE, no done pulse.
REQ-008 io_tick  input  1  decrement enable; one decrement per cycle with io_tick=1 while RUN.
REQ-009 io_autoReload  input  1  sampled at each expiry: 1 = reload and continue, 0 = stop.
REQ-010 io_value  output  WIDTH  current count register.
REQ-011 io_busy  output  1  high while state is RUN.
REQ-012 io_done  output  1  registered one-cycle pulse on every expiry.
REQ-013 io_zero  output  1  combinational flag, io_value == 0.

Function
REQ-014 State machine has two states: IDLE and RUN.
REQ-015 IDLE, io_load=1: count <= io_loadValue; reload <= io_loadValue.
REQ-016 IDLE, io_start=1: use the effective count (io_loadValue if io_load=1 in the same cycle, else the current count); nonzero -> RUN next cycle; zero -> stay IDLE and pulse io_done next cycle.
REQ-017 RUN, io_abort=1: go to IDLE next cycle; count holds; no io_done; io_abort overrides io_tick in that cycle.
REQ-018 RUN, io_tick=1, count > 1: count <= count - 1.
REQ-019 RUN, io_tick=1, count == 1: expiry; io_done=1 next cycle.
REQ-020 At expiry with io_autoReload=1: count <= reload; stay RUN.
REQ-021 At expiry with io_autoReload=0: count <= 0; go to IDLE.
REQ-022 RUN, io_tick=0: count holds.
REQ-023 In RUN, io_load and io_start are ignored; the reload register is unchanged.
REQ-024 In IDLE, io_abort, io_tick and io_autoReload have no effect.
REQ-025 io_done is high for exactly one cycle per expiry; back-to-back expiries with reload=1 and continuous tick produce io_done on every cycle.
REQ-026 The count never wraps below 0 or above 2^WIDTH-1.
REQ-027 Latency: first decrement occurs on the first io_tick=1 cycle after entering RUN; the io_start cycle itself never decrements.

Reset
REQ-028 While reset is low: count=0, reload=0, state=IDLE, io_done=0, io_busy=0, io_zero=1.
REQ-029 Reset asserted mid-RUN aborts immediately with no io_done pulse; the block resumes in IDLE after reset deasserts.

Structure
REQ-030 The shared package holds the state enumeration (IDLE, RUN) and the default WIDTH constant.
REQ-031 The block is a single module with no sub-module; tick generation (prescaler) stays outside.

Verification
REQ-032 Load 3, start, tick held 1, autoReload=0 -> io_value 3,2,1,0; io_done one cycle after io_value leaves 1; io_busy falls with io_done.
REQ-033 Load 2, start, tick held 1, autoReload=1 -> io_value 2,1,2,1,...; io_done every 2nd cycle; io_busy stays 1.
REQ-034 Load 5, start, tick every 3rd cycle, abort at io_value=3 -> IDLE, io_value holds 3, no io_done.
REQ-035 Load 0 and start in the same cycle -> io_busy stays 0; io_done pulses once next cycle; io_zero=1.
REQ-036 Load 1, start, autoReload=1, tick held 1 -> io_value stays 1; io_done high every cycle.
REQ-037 Load 7, start, reset low mid-count -> all outputs match REQ-028 immediately; no io_done; IDLE after release.
